bp_writeback_control: RTL and testbench
=======================================

# bp_writeback_control

Reads result lines out of the on-chip BP buffer array and streams them into the DDR write-FIFO. It is the return path of the DDR-to-BP loader: one configuration pulse selects a start MAC column, a start buffer address, a line width and a line count, and the block emits a DDR write request followed by the packed words. It sits between the BP BRAM read ports and the DDR write-channel FIFO.

## Interface
Parameters:
- X_MAC, 4, MAC columns per mesh row (buffer index = mac + X_MAC*mesh)
- X_MESH, 8, mesh rows; one DATA_LEN lane per row in each DDR word
- DDR_ADDR_LEN, 32, DDR address width
- DDR_DATA_LEN, 256, DDR word width; must equal X_MESH*DATA_LEN
- ADDR_LEN, 16, BP buffer address width
- DATA_LEN, 32, BP buffer data width
- SINGLE_LEN, 24, width of length/width fields
- BUFFER_NUM, X_MAC*X_MESH, number of BP buffers

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- conf  in  1  start pulse; sampled only when idle
- data_ddr_byte  in  SINGLE_LEN  DDR transfer length, passed to ddr_len
- ddr_st_addr  in  DDR_ADDR_LEN  DDR destination start address
- BP_st_addr  in  ADDR_LEN  buffer start address for every line
- BP_st_num  in  2  first MAC column read
- Line_cnt  in  2  number of lines minus one (1..4 lines)
- Line_width  in  SINGLE_LEN  words per line
- ddr_st_addr_out  out  DDR_ADDR_LEN  latched ddr_st_addr
- ddr_len  out  SINGLE_LEN  latched data_ddr_byte
- ddr_conf  out  1  one-cycle write-request pulse
- ddr_fifo_full  in  1  DDR write FIFO full
- ddr_fifo_wr  out  1  write strobe (combinational)
- ddr_fifo_data  out  DDR_DATA_LEN  write data
- BP_addr_out  out  ADDR_LEN*BUFFER_NUM  read address, same value broadcast to all buffers
- BP_data_in  in  DATA_LEN*BUFFER_NUM  buffer read data, 1-cycle latency after address
- idle  out  1  high when no transfer, no in-flight read, skid empty

## Operation
- States IDLE, RUN, DRAIN. IDLE: conf latches all inputs, sets col=BP_st_num, line=0, word=0, addr=BP_st_addr; -> RUN. conf outside IDLE ignored.
- Line_width==0 at conf: no ddr_conf, no words, stay IDLE.
- RUN: issue one read per cycle when (skid occupancy + in-flight) < 2. After issue: word+1, addr+1; at word==Line_width-1: word=0, addr=BP_st_addr, col=col+1 (2-bit wrap, mod 4), line+1; after last word of line Line_cnt -> DRAIN.
- Read-data capture: lane m of the packed word = BP_data_in[(col_issued + X_MAC*m)*DATA_LEN +: DATA_LEN], col_issued registered with the read.
- Skid: 2-entry FIFO. ddr_fifo_wr = skid not empty && !ddr_fifo_full; ddr_fifo_data = skid head; pop on ddr_fifo_wr.
- DRAIN -> IDLE when in-flight==0 and skid empty.
- ddr_conf/ddr_st_addr_out/ddr_len: updated and pulsed the cycle after an accepted conf.
- Total words = Line_width*(Line_cnt+1), in order line-major, address-minor.

## Timing
- Reset: ddr_conf=0, ddr_len=0, ddr_st_addr_out=0, ddr_fifo_wr=0, BP_addr_out=0, idle=1; skid and in-flight dropped; reset mid-transfer aborts without further writes.
- conf at cycle 0 -> ddr_conf high cycle 1 only; first BP_addr_out valid cycle 1; data cycle 2; first ddr_fifo_wr cycle 2 if not full.
- Full throughput 1 word/cycle with ddr_fifo_full low.
- ddr_fifo_full high: wr held low, head held stable; reads stop once skid+in-flight reaches 2; resume within 1 cycle of full falling, no loss or duplication.
- idle falls cycle after conf; rises cycle after last word written.

## Configuration
- BPWB_LAST_EN defined: extra output ddr_fifo_last (1 bit), high with ddr_fifo_wr on the final word of the transfer only, 0 at reset.
- Undefined: port absent; all other behaviour identical.

## Test plan
- Reset then idle: outputs at reset values, idle=1, conf with Line_width=0 -> no ddr_conf, idle stays 1.
- Line_width=4, Line_cnt=1, BP_st_num=2, BP_st_addr=0x10, full low -> ddr_conf at cycle 1, 8 writes on consecutive cycles, addrs 0x10..0x13 twice, columns 2 then 3.
- BP_st_num=3, Line_cnt=1 -> second line reads column 0 (wrap).
- Toggle ddr_fifo_full randomly during 64-word transfer -> exactly 64 writes, data in order, never wr while full.
- rst_n low at word 5 of 16 -> no further writes, idle=1 next cycle; fresh conf runs cleanly.
- BPWB_LAST_EN build, 3-word transfer -> ddr_fifo_last high only with third write.

Source files
------------

// File: rtl/bp_writeback_control.sv
// BP buffer -> DDR write-FIFO return path: reads result lines from the BP
// buffers and streams packed words into the DDR write FIFO.
// Ports: clk/rst_n; conf + transfer config in; ddr_conf/ddr_st_addr_out/
// ddr_len request out; ddr_fifo_full/wr/data FIFO side; BP_addr_out/
// BP_data_in buffer side; idle status.
// Optional: define BPWB_LAST_EN to add ddr_fifo_last (final-word marker).
module bp_writeback_control #(
  parameter int X_MAC        = 4,
  parameter int X_MESH       = 8,
  parameter int DDR_ADDR_LEN = 32,
  parameter int DDR_DATA_LEN = 256,
  parameter int ADDR_LEN     = 16,
  parameter int DATA_LEN     = 32,
  parameter int SINGLE_LEN   = 24,
  parameter int BUFFER_NUM   = X_MAC*X_MESH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           conf,
  input  logic [SINGLE_LEN-1:0]          data_ddr_byte,
  input  logic [DDR_ADDR_LEN-1:0]        ddr_st_addr,
  input  logic [ADDR_LEN-1:0]            BP_st_addr,
  input  logic [1:0]                     BP_st_num,
  input  logic [1:0]                     Line_cnt,
  input  logic [SINGLE_LEN-1:0]          Line_width,
  output logic [DDR_ADDR_LEN-1:0]        ddr_st_addr_out,
  output logic [SINGLE_LEN-1:0]          ddr_len,
  output logic                           ddr_conf,
  input  logic                           ddr_fifo_full,
  output logic                           ddr_fifo_wr,
  output logic [DDR_DATA_LEN-1:0]        ddr_fifo_data,
  output logic [ADDR_LEN*BUFFER_NUM-1:0] BP_addr_out,
  input  logic [DATA_LEN*BUFFER_NUM-1:0] BP_data_in,
`ifdef BPWB_LAST_EN
  output logic                           ddr_fifo_last,
`endif
  output logic                           idle
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  localparam logic [SINGLE_LEN-1:0] W_ONE = 1;
  localparam logic [ADDR_LEN-1:0]   A_ONE = 1;

  state_t state_q, state_d;

  logic [SINGLE_LEN-1:0] lw_q, word_q;
  logic [1:0]            lc_q, line_q, col_q, icol_q;
  logic [ADDR_LEN-1:0]   base_q, addr_q;
  logic                  infl_q;

  logic [DDR_DATA_LEN-1:0] skid_mem [2];
  logic                    rp_q, wp_q;
  logic [1:0]              cnt_q;

  logic [DDR_DATA_LEN-1:0] rd_word;
  logic start, issue, end_line, last_word;
  logic push, pop;
  logic [1:0] occ;

`ifdef BPWB_LAST_EN
  logic       ilast_q;
  logic [1:0] skid_last;
`endif

  assign start     = (state_q == S_IDLE) && conf && (Line_width != '0);
  assign end_line  = (word_q == lw_q - W_ONE);
  assign last_word = end_line && (line_q == lc_q);

  // FIFO side: bypass the in-flight word when the skid is empty so the
  // first write lands one cycle after the read address.
  assign ddr_fifo_wr   = ((cnt_q != 2'd0) || infl_q) && !ddr_fifo_full;
  assign ddr_fifo_data = (cnt_q != 2'd0) ? skid_mem[rp_q] : rd_word;
  assign pop  = ddr_fifo_wr && (cnt_q != 2'd0);
  assign push = infl_q && !(ddr_fifo_wr && (cnt_q == 2'd0));

  // Occupancy after this cycle's write; counting the pop lets reads
  // resume the same cycle the FIFO stops being full.
  assign occ = cnt_q + {1'b0, infl_q} - {1'b0, ddr_fifo_wr};

  assign BP_addr_out = {BUFFER_NUM{addr_q}};

`ifdef BPWB_LAST_EN
  assign ddr_fifo_last = ddr_fifo_wr &&
    ((cnt_q != 2'd0) ? skid_last[rp_q] : ilast_q);
`endif

  always_comb begin
    rd_word = '0;
    for (int m = 0; m < X_MESH; m++) begin
      rd_word[m*DATA_LEN +: DATA_LEN] =
        BP_data_in[(int'(icol_q) + X_MAC*m)*DATA_LEN +: DATA_LEN];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (issue && last_word) state_d = S_DRAIN;
      S_DRAIN: if (occ == 2'd0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idle  = (state_q == S_IDLE);
    issue = (state_q == S_RUN) && (occ < 2'd2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lw_q            <= '0;
      lc_q            <= '0;
      base_q          <= '0;
      col_q           <= '0;
      line_q          <= '0;
      word_q          <= '0;
      addr_q          <= '0;
      infl_q          <= 1'b0;
      icol_q          <= '0;
      ddr_conf        <= 1'b0;
      ddr_st_addr_out <= '0;
      ddr_len         <= '0;
    end else begin
      ddr_conf <= start;
      infl_q   <= issue;
      icol_q   <= col_q;
      if (start) begin
        lw_q            <= Line_width;
        lc_q            <= Line_cnt;
        base_q          <= BP_st_addr;
        col_q           <= BP_st_num;
        line_q          <= '0;
        word_q          <= '0;
        addr_q          <= BP_st_addr;
        ddr_st_addr_out <= ddr_st_addr;
        ddr_len         <= data_ddr_byte;
      end else if (issue) begin
        if (end_line) begin
          word_q <= '0;
          addr_q <= base_q;
          col_q  <= col_q + 2'd1;
          line_q <= line_q + 2'd1;
        end else begin
          word_q <= word_q + W_ONE;
          addr_q <= addr_q + A_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rp_q  <= 1'b0;
      wp_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        skid_mem[wp_q] <= rd_word;
        wp_q           <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef BPWB_LAST_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ilast_q   <= 1'b0;
      skid_last <= '0;
    end else begin
      ilast_q <= issue && last_word;
      if (push) skid_last[wp_q] <= ilast_q;
    end
  end
`endif

endmodule

// File: tb/tb_bp_writeback_control.sv
// Self-checking bench for bp_writeback_control: table of transfers
// plus zero-width and mid-transfer reset sequences.
module tb_bp_writeback_control;

  logic         clk = 0;
  logic         rst_n;
  logic         conf;
  logic [23:0]  data_ddr_byte;
  logic [31:0]  ddr_st_addr;
  logic [15:0]  BP_st_addr;
  logic [1:0]   BP_st_num;
  logic [1:0]   Line_cnt;
  logic [23:0]  Line_width;
  logic [31:0]  ddr_st_addr_out;
  logic [23:0]  ddr_len;
  logic         ddr_conf;
  logic         ddr_fifo_full;
  logic         ddr_fifo_wr;
  logic [255:0] ddr_fifo_data;
  logic [511:0] BP_addr_out;
  logic [1023:0] BP_data_in;
  logic         idle;
`ifdef BPWB_LAST_EN
  logic         ddr_fifo_last;
`endif

  int total = 0;
  int bad   = 0;

  bp_writeback_control dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .conf            (conf),
    .data_ddr_byte   (data_ddr_byte),
    .ddr_st_addr     (ddr_st_addr),
    .BP_st_addr      (BP_st_addr),
    .BP_st_num       (BP_st_num),
    .Line_cnt        (Line_cnt),
    .Line_width      (Line_width),
    .ddr_st_addr_out (ddr_st_addr_out),
    .ddr_len         (ddr_len),
    .ddr_conf        (ddr_conf),
    .ddr_fifo_full   (ddr_fifo_full),
    .ddr_fifo_wr     (ddr_fifo_wr),
    .ddr_fifo_data   (ddr_fifo_data),
    .BP_addr_out     (BP_addr_out),
    .BP_data_in      (BP_data_in),
`ifdef BPWB_LAST_EN
    .ddr_fifo_last   (ddr_fifo_last),
`endif
    .idle            (idle)
  );

  always #5 clk = ~clk;

  // BP buffer model: 1-cycle read latency, data tags buffer and address.
  always @(posedge clk) begin
    for (int b = 0; b < 32; b++) begin
      BP_data_in[b*32 +: 32] <= {8'(b), 8'hC3, BP_addr_out[b*16 +: 16]};
    end
  end

  typedef struct {
    int          lw;
    int          lc;
    int          st;
    logic [15:0] base;
    logic [31:0] daddr;
    logic [23:0] dlen;
    bit          rnd;
    int          words;
  } vec_t;

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] exp_word(input vec_t v, input int n);
    logic [255:0] w;
    int l, k, col;
    logic [15:0] a;
    l   = n / v.lw;
    k   = n % v.lw;
    col = (v.st + l) % 4;
    a   = v.base + 16'(k);
    for (int m = 0; m < 8; m++) begin
      w[m*32 +: 32] = {8'(col + 4*m), 8'hC3, a};
    end
    return w;
  endfunction

  task automatic start_conf(input vec_t v);
    @(posedge clk); #1;
    Line_width    = 24'(v.lw);
    Line_cnt      = 2'(v.lc);
    BP_st_num     = 2'(v.st);
    BP_st_addr    = v.base;
    ddr_st_addr   = v.daddr;
    data_ddr_byte = v.dlen;
    ddr_fifo_full = 1'b0;
    conf          = 1'b1;
    @(posedge clk); #1;
    conf = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int cyc, nwr, firstc, lastc;
    bit done;
    start_conf(v);
    if (v.rnd) ddr_fifo_full = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("ddr_conf_c1", ddr_conf, 1);
    chk("ddr_addr_out", ddr_st_addr_out, v.daddr);
    chk("ddr_len", ddr_len, v.dlen);
    chk("idle_c1", idle, 0);
    chk("bp_addr_c1", BP_addr_out[511:496], v.base);
    cyc = 1; nwr = 0; firstc = 0; lastc = 0; done = 0;
    while (!done && cyc < 600) begin
      @(posedge clk); #1;
      cyc++;
      if (v.rnd) ddr_fifo_full = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (cyc == 2) chk("ddr_conf_c2", ddr_conf, 0);
`ifdef BPWB_LAST_EN
      chk("last", ddr_fifo_last,
          ddr_fifo_wr && (nwr == v.words - 1));
`endif
      if (ddr_fifo_wr) begin
        chk("wr_while_full", ddr_fifo_full, 0);
        if (nwr < v.words) chk("data", ddr_fifo_data, exp_word(v, nwr));
        else chk("extra_write", 1, 0);
        if (nwr == 0) firstc = cyc;
        lastc = cyc;
        nwr++;
      end
      if (idle) done = 1;
    end
    ddr_fifo_full = 1'b0;
    chk("timeout", done, 1);
    chk("word_count", nwr, v.words);
    chk("idle_rise", cyc, lastc + 1);
    if (!v.rnd) begin
      chk("first_wr_cycle", firstc, 2);
      chk("last_wr_cycle", lastc, 1 + v.words);
    end
  endtask

  vec_t vecs[6];
  vec_t rv;
  int   nw;

  initial begin
    vecs[0] = '{4, 1, 2, 16'h0010, 32'h8000_0000, 24'd256, 0, 8};
    vecs[1] = '{3, 1, 3, 16'h0020, 32'h0000_1000, 24'd192, 0, 6};
    vecs[2] = '{16, 3, 1, 16'h0100, 32'h1234_5678, 24'd2048, 1, 64};
    vecs[3] = '{1, 0, 0, 16'hFFFF, 32'hDEAD_BEE0, 24'd32, 0, 1};
    vecs[4] = '{5, 2, 0, 16'h0007, 32'h0000_0040, 24'd480, 1, 15};
    vecs[5] = '{3, 0, 1, 16'h0200, 32'h0000_0080, 24'd96, 0, 3};

    rst_n = 0; conf = 0; ddr_fifo_full = 0;
    Line_width = 0; Line_cnt = 0; BP_st_num = 0; BP_st_addr = 0;
    ddr_st_addr = 0; data_ddr_byte = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ddr_conf", ddr_conf, 0);
    chk("rst_ddr_len", ddr_len, 0);
    chk("rst_ddr_addr", ddr_st_addr_out, 0);
    chk("rst_wr", ddr_fifo_wr, 0);
    chk("rst_bp_addr", BP_addr_out, 0);
    chk("rst_idle", idle, 1);
    @(posedge clk); #1;
    rst_n = 1;

    rv = '{0, 1, 0, 16'h0033, 32'h0000_0100, 24'd0, 0, 0};
    start_conf(rv);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("zw_ddr_conf", ddr_conf, 0);
      chk("zw_idle", idle, 1);
      chk("zw_wr", ddr_fifo_wr, 0);
    end

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    rv = '{16, 0, 1, 16'h0040, 32'h0000_2000, 24'd512, 0, 16};
    start_conf(rv);
    nw = 0;
    for (int c = 0; c < 40 && nw < 5; c++) begin
      @(negedge clk);
      if (ddr_fifo_wr) nw++;
    end
    chk("rst_seq_reach5", nw, 5);
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_idle", idle, 1);
    chk("mid_rst_wr", ddr_fifo_wr, 0);
    chk("mid_rst_ddr_conf", ddr_conf, 0);
    chk("mid_rst_bp_addr", BP_addr_out, 0);
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_wr", ddr_fifo_wr, 0);
    end
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
